// File: rtl/switch_input_pkg.sv
// ---------------------------------------------------------------------------
// switch_input_pkg
//
// Shared definitions for the switch input port:
//   - register address map (LEVEL, RISE, FALL, MASK)
//   - cnt_width(): derives the per-bit debounce counter width from the
//     debounce length, equal to $clog2(cycles) for cycles >= 1.
//
// Optional feature macro used by the port: SWITCH_IRQ_EN (MASK register and
// irq output).
// ---------------------------------------------------------------------------
package switch_input_pkg;

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_RISE  = 2'd1;
  localparam logic [1:0] ADDR_FALL  = 2'd2;
  localparam logic [1:0] ADDR_MASK  = 2'd3;

  // Smallest w with 2**w >= cycles. The counter only ever reaches cycles-1,
  // so this width is always sufficient.
  function automatic int cnt_width(input int cycles);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(cycles)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//
// One-pin synchroniser + debouncer.
//   - Two flip-flop synchroniser; the second stage is the "sync" level.
//   - A counter runs while sync differs from the accepted stable level and
//     clears whenever they agree. When the counter has reached
//     DEBOUNCE_CYCLES-1 and the mismatch still holds, the new level is
//     accepted and the counter clears.
//   - rise_pulse / fall_pulse are combinational and high during the cycle
//     whose closing edge changes stable, so a flag register fed from them
//     sets on the same edge that stable changes.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   pin        raw asynchronous pin
//   stable     debounced level
//   rise_pulse stable is about to go 0->1 at the next edge
//   fall_pulse stable is about to go 1->0 at the next edge
// ---------------------------------------------------------------------------
module debounce_bit
  import switch_input_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 1000000,
  localparam int CNT_WIDTH       = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 meta_reg;
  logic                 sync_reg;
  logic                 stable_reg;
  logic                 stable_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 accept;

  // The mismatch must still hold on the edge where the count is complete;
  // a glitch that returns to the stable level just clears the counter.
  assign accept = (sync_reg != stable_reg) && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next    = cnt_reg;
    stable_next = stable_reg;
    if (sync_reg == stable_reg) begin
      cnt_next = '0;
    end else if (accept) begin
      cnt_next    = '0;
      stable_next = sync_reg;
    end else begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      meta_reg   <= pin;
      sync_reg   <= meta_reg;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign stable     = stable_reg;
  assign rise_pulse = accept & sync_reg;
  assign fall_pulse = accept & ~sync_reg;

endmodule

// File: rtl/switch_input_port.sv
// ---------------------------------------------------------------------------
// switch_input_port
//
// CPU-side input peripheral for board switches/buttons. Each pin is
// synchronised and debounced independently (debounce_bit), debounced edges
// are captured in sticky RISE/FALL flags, and everything is visible through
// a 4-entry register interface:
//   addr 0 LEVEL  debounced levels, read-only
//   addr 1 RISE   sticky rising-edge flags, write-1-to-clear
//   addr 2 FALL   sticky falling-edge flags, write-1-to-clear
//   addr 3 MASK   irq enable mask (reads 0, writes ignored without the
//                 SWITCH_IRQ_EN build option)
//
// Build option: `define SWITCH_IRQ_EN adds MASK storage and the irq output,
// irq = registered |((rise | fall) & mask).
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   pin_in   raw asynchronous pins
//   addr     register address
//   rd_en    read strobe; rdata/rvalid answer in the following cycle
//   wr_en    write strobe
//   wdata    write data
//   rdata    read data, held between reads
//   rvalid   one-cycle pulse marking valid rdata
//   irq      interrupt request (SWITCH_IRQ_EN only)
// ---------------------------------------------------------------------------
module switch_input_port
  import switch_input_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
`ifdef SWITCH_IRQ_EN
  output logic             rvalid,
  output logic             irq
`else
  output logic             rvalid
`endif
);

  logic [WIDTH-1:0] level_vec;
  logic [WIDTH-1:0] rise_pulse_vec;
  logic [WIDTH-1:0] fall_pulse_vec;

  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] fall_next;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rdata_reg;
  logic             rvalid_reg;

`ifdef SWITCH_IRQ_EN
  logic [WIDTH-1:0] mask_reg;
  logic             irq_reg;
`endif

  // ---------------------------------------------------------------- pins
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .pin        (pin_in[gi]),
        .stable     (level_vec[gi]),
        .rise_pulse (rise_pulse_vec[gi]),
        .fall_pulse (fall_pulse_vec[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------- flags
  assign rise_clr = (wr_en && (addr == ADDR_RISE)) ? wdata : '0;
  assign fall_clr = (wr_en && (addr == ADDR_FALL)) ? wdata : '0;

  // Setting is OR-ed in after clearing so that a new edge in the same cycle
  // as a write-1-to-clear leaves the flag set.
  assign rise_next = (rise_reg & ~rise_clr) | rise_pulse_vec;
  assign fall_next = (fall_reg & ~fall_clr) | fall_pulse_vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      rise_reg <= rise_next;
      fall_reg <= fall_next;
    end
  end

`ifdef SWITCH_IRQ_EN
  // ---------------------------------------------------------------- mask/irq
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      if (wr_en && (addr == ADDR_MASK)) begin
        mask_reg <= wdata;
      end
      // Built from the current flag/mask registers, so irq trails a flag
      // set, clear or mask change by exactly one cycle.
      irq_reg <= |((rise_reg | fall_reg) & mask_reg);
    end
  end

  assign irq = irq_reg;
`endif

  // ---------------------------------------------------------------- read
  // The mux looks at the registers before the current edge updates them, so
  // a read alongside a write to the same address returns the old value.
  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_LEVEL: rd_mux = level_vec;
      ADDR_RISE:  rd_mux = rise_reg;
      ADDR_FALL:  rd_mux = fall_reg;
`ifdef SWITCH_IRQ_EN
      ADDR_MASK:  rd_mux = mask_reg;
`else
      ADDR_MASK:  rd_mux = '0;
`endif
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= rd_en;
      if (rd_en) begin
        rdata_reg <= rd_mux;
      end
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;

endmodule

// File: tb/tb_switch_input_port.sv
// ---------------------------------------------------------------------------
// tb_switch_input_port
//
// Bench for switch_input_port with WIDTH=8, DEBOUNCE_CYCLES=4. A reference
// model describes the port in terms of pin sample history: a level is
// accepted when the synchronised pin has shown the opposite value for the
// last DEBOUNCE_CYCLES samples. A directed sequence pins down latency,
// glitch rejection, write-1-to-clear priority and reset behaviour, then a
// randomized run exercises everything against the model.
// Define SWITCH_IRQ_EN to build and check the interrupt path.
// ---------------------------------------------------------------------------
module tb_switch_input_port;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] pin_in;
  logic [1:0]   addr;
  logic         rd_en;
  logic         wr_en;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         rvalid;
`ifdef SWITCH_IRQ_EN
  logic         irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  switch_input_port #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_in  (pin_in),
    .addr    (addr),
    .rd_en   (rd_en),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .rdata   (rdata),
`ifdef SWITCH_IRQ_EN
    .rvalid  (rvalid),
    .irq     (irq)
`else
    .rvalid  (rvalid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // hist[0] is the pin sample taken at the previous edge; the synchronised
  // value seen at an edge is two samples old, so the acceptance window at
  // an edge is hist[1..D].
  logic [W-1:0] hist [0:D];
  logic [W-1:0] m_level, m_rise, m_fall, m_mask, m_rdata;
  logic         m_rvalid;
`ifdef SWITCH_IRQ_EN
  logic         m_irq;
`endif

  function automatic logic [W-1:0] win_and();
    logic [W-1:0] r;
    r = '1;
    for (int j = 1; j <= D; j++) r = r & hist[j];
    return r;
  endfunction

  function automatic logic [W-1:0] win_or();
    logic [W-1:0] r;
    r = '0;
    for (int j = 1; j <= D; j++) r = r | hist[j];
    return r;
  endfunction

  function automatic logic [W-1:0] reg_value(input logic [1:0] a);
    case (a)
      2'd0:    return m_level;
      2'd1:    return m_rise;
      2'd2:    return m_fall;
      default: return m_mask;
    endcase
  endfunction

  function automatic logic [W-1:0] wr_clear(input logic [1:0] a);
    return (wr_en && addr == a) ? wdata : '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_level  <= '0;
      m_rise   <= '0;
      m_fall   <= '0;
      m_mask   <= '0;
      m_rdata  <= '0;
      m_rvalid <= 1'b0;
`ifdef SWITCH_IRQ_EN
      m_irq    <= 1'b0;
`endif
      for (int j = 0; j <= D; j++) hist[j] <= '0;
    end else begin
      m_rvalid <= rd_en;
      if (rd_en) m_rdata <= reg_value(addr);
      m_rise  <= (m_rise & ~wr_clear(2'd1)) | (win_and() & ~m_level);
      m_fall  <= (m_fall & ~wr_clear(2'd2)) | (~win_or() & m_level);
      m_level <= (m_level | (win_and() & ~m_level)) & ~(~win_or() & m_level);
`ifdef SWITCH_IRQ_EN
      m_irq <= |((m_rise | m_fall) & m_mask);
      if (wr_en && addr == 2'd3) m_mask <= wdata;
`endif
      for (int j = D; j >= 1; j--) hist[j] <= hist[j-1];
      hist[0] <= pin_in;
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("model_rdata", 32'(rdata), 32'(m_rdata));
`ifdef SWITCH_IRQ_EN
    chk("model_irq", 32'(irq), 32'(m_irq));
`endif
  end

  // ---------------------------------------------------------------- helpers
  // All tasks start and end at a falling edge, so every strobe is sampled by
  // exactly one rising edge.
  task automatic do_read(input logic [1:0] a, input logic [W-1:0] exp, input string nm);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    $display("read  addr=%0d rdata=%h rvalid=%0d expect=%h (%s)", a, rdata, rvalid, exp, nm);
    chk({nm, "_rvalid"}, 32'(rvalid), 32'd1);
    chk(nm, 32'(rdata), 32'(exp));
  endtask

  task automatic do_write(input logic [1:0] a, input logic [W-1:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    $display("write addr=%0d wdata=%h", a, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n = 1'b0;
    pin_in  = '0;
    addr    = '0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wdata   = '0;
    wait_neg(3);
    chk("reset_rdata", 32'(rdata), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    #2 reset_n = 1'b1;

    // Idle read after reset.
    do_read(2'd0, 8'h00, "idle_level");

    // Level change: accepted on the 6th edge after the change.
    pin_in = 8'h05;
    wait_neg(5);
    do_read(2'd0, 8'h00, "level_edge6_old");
    do_read(2'd0, 8'h05, "level_edge7_new");
    do_read(2'd1, 8'h05, "rise_after_05");
    do_read(2'd2, 8'h00, "fall_after_05");

    // Write-1-to-clear.
    do_write(2'd1, 8'h01);
    do_read(2'd1, 8'h04, "rise_w1c_bit0");
    do_write(2'd0, 8'hFF);
    do_read(2'd0, 8'h05, "level_ro");

    // Clear coinciding with a new rise on bit 2: set wins.
    do_write(2'd1, 8'h04);
    pin_in = 8'h01;
    wait_neg(10);
    do_read(2'd2, 8'h04, "fall_bit2");
    do_read(2'd1, 8'h00, "rise_cleared");
    pin_in = 8'h05;
    wait_neg(5);
    do_write(2'd1, 8'h04);
    do_read(2'd1, 8'h04, "rise_set_wins");

    // Glitch rejection on bit 0.
    pin_in = 8'h04;
    wait_neg(10);
    do_write(2'd1, 8'hFF);
    do_write(2'd2, 8'hFF);
    pin_in = 8'h05;
    wait_neg(3);
    pin_in = 8'h04;
    wait_neg(8);
    do_read(2'd0, 8'h04, "glitch3_level");
    do_read(2'd1, 8'h00, "glitch3_rise");
    pin_in = 8'h05;
    wait_neg(4);
    pin_in = 8'h04;
    wait_neg(10);
    do_read(2'd1, 8'h01, "pulse4_rise");
    do_read(2'd2, 8'h01, "pulse4_fall");

    // Reset in the middle of a debounce run and of a read.
    pin_in = 8'hFF;
    wait_neg(1);
    do_read(2'd0, 8'h04, "pre_reset_level");
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_rdata", 32'(rdata), 32'd0);
    chk("async_reset_rvalid", 32'(rvalid), 32'd0);
    wait_neg(2);
    #2 reset_n = 1'b1;
    wait_neg(5);
    do_read(2'd0, 8'h00, "post_reset_edge6");
    do_read(2'd0, 8'hFF, "post_reset_edge7");
    do_read(2'd2, 8'h00, "post_reset_fall");
    do_write(2'd1, 8'hFF);

`ifdef SWITCH_IRQ_EN
    pin_in = 8'hFD;
    wait_neg(10);
    do_write(2'd2, 8'hFF);
    do_write(2'd3, 8'h02);
    do_read(2'd3, 8'h02, "mask_rw");
    chk("irq_idle", 32'(irq), 32'd0);
    pin_in = 8'hFF;
    wait_neg(6);
    chk("irq_flag_edge", 32'(irq), 32'd0);
    wait_neg(1);
    chk("irq_rises", 32'(irq), 32'd1);
    do_write(2'd1, 8'h02);
    chk("irq_w1c_edge", 32'(irq), 32'd1);
    wait_neg(1);
    chk("irq_falls", 32'(irq), 32'd0);
    pin_in = 8'hFE;
    wait_neg(10);
    pin_in = 8'hFF;
    wait_neg(10);
    chk("irq_masked_bit0", 32'(irq), 32'd0);
    do_read(2'd1, 8'h01, "rise_bit0_masked");
`else
    do_write(2'd3, 8'hFF);
    do_read(2'd3, 8'h00, "mask_absent");
`endif

    // Randomized traffic checked against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rd_en = 1'b0;
      wr_en = 1'b0;
      if ($urandom_range(0, 399) == 0) begin
        $display("reset pulse at cycle %0d", cyc);
        #2 reset_n = 1'b0;
        wait_neg(2);
        #2 reset_n = 1'b1;
      end else begin
        if ($urandom_range(0, 5) == 0)
          pin_in = pin_in ^ (8'($urandom) & 8'($urandom));
        addr = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 2) == 0) rd_en = 1'b1;
        if ($urandom_range(0, 4) == 0) begin
          wr_en = 1'b1;
          wdata = 8'($urandom);
        end
        if (rd_en || wr_en)
          $display("rand cyc=%0d pin=%h addr=%0d rd=%0d wr=%0d wdata=%h",
                   cyc, pin_in, addr, rd_en, wr_en, wdata);
      end
    end
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    wait_neg(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
